// File: rtl/vga_dither_out.sv
// VGA colour output stage: reduces IN_W-bit RGB to OUT_W bits by truncation, rounding or
// 4x4 ordered dither, with syncs and blanking kept aligned through a 2-stage pipeline.
module vga_dither_out #(
  parameter int unsigned IN_W     = 8,
  parameter int unsigned OUT_W    = 4,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic             CLK_25MHZ,
  input  logic             RESET_N,
  input  logic [1:0]       MODE,
  input  logic             VGA_DE_IN,
  input  logic             VGA_HSYNC_IN,
  input  logic             VGA_VSYNC_IN,
  input  logic [IN_W-1:0]  VGA_RED_IN,
  input  logic [IN_W-1:0]  VGA_GREEN_IN,
  input  logic [IN_W-1:0]  VGA_BLUE_IN,
  output logic             VGA_HSYNC,
  output logic             VGA_VSYNC,
  output logic [OUT_W-1:0] VGA_RED,
  output logic [OUT_W-1:0] VGA_GREEN,
  output logic [OUT_W-1:0] VGA_BLUE,
  output logic [1:0]       MODE_ACTIVE
);

  if (OUT_W < 1 || OUT_W >= IN_W) begin : g_bad_width
    $error("vga_dither_out: OUT_W must satisfy 1 <= OUT_W < IN_W");
  end

  localparam int unsigned S      = IN_W - OUT_W;
  localparam int unsigned SumW   = IN_W + 1;
  localparam int unsigned WideW  = IN_W + 5;
  localparam int unsigned ShL    = (S >= 4) ? S - 4 : 0;
  localparam int unsigned ShR    = (S >= 4) ? 0 : 4 - S;
  localparam logic [IN_W:0] RoundBias = SumW'(1) << (S - 1);

  function automatic logic [3:0] bayer(input logic [1:0] y, input logic [1:0] x);
    logic [3:0] b;
    unique case ({y, x})
      4'h0: b = 4'd0;   4'h1: b = 4'd8;   4'h2: b = 4'd2;   4'h3: b = 4'd10;
      4'h4: b = 4'd12;  4'h5: b = 4'd4;   4'h6: b = 4'd14;  4'h7: b = 4'd6;
      4'h8: b = 4'd3;   4'h9: b = 4'd11;  4'ha: b = 4'd1;   4'hb: b = 4'd9;
      4'hc: b = 4'd15;  4'hd: b = 4'd7;   4'he: b = 4'd13;  default: b = 4'd5;
    endcase
    return b;
  endfunction

  // Keep only carry plus the top OUT_W bits; the low bits matter only through the carry.
  function automatic logic [OUT_W:0] biased(input logic [IN_W-1:0] c,
                                            input logic [IN_W:0]   bias);
    return (OUT_W + 1)'(({1'b0, c} + bias) >> S);
  endfunction

  function automatic logic [OUT_W-1:0] sat(input logic [OUT_W:0] s);
    return s[OUT_W] ? '1 : s[OUT_W-1:0];
  endfunction

  logic [1:0]       x_q, x_d, y_q, y_d, mode_q, mode_d;
  logic             de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, black1_q, black1_d;
  logic [OUT_W:0]   r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic             hs2_q, hs2_d, vs2_q, vs2_d;
  logic [OUT_W-1:0] r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
  logic [IN_W:0]    bias;
  logic             vs_act, blank;

  always_comb begin
    vs_act = (VGA_VSYNC_IN == SYNC_POL);
    x_d    = x_q;
    y_d    = y_q;
    mode_d = mode_q;
    if (VGA_DE_IN) begin
      x_d = x_q + 2'd1;
    end else if (de1_q) begin
      x_d = 2'd0;
      y_d = y_q + 2'd1;
    end
    if (vs_act) y_d = 2'd0;
    // vs1_q holds last cycle's VSYNC_IN, giving the inactive-to-active edge.
    if (vs_act && (vs1_q != SYNC_POL)) mode_d = MODE;

    unique case (mode_q)
      2'd1:    bias = RoundBias;
      2'd2:    bias = SumW'((WideW'(bayer(y_q, x_q)) << ShL) >> ShR);
      default: bias = '0;
    endcase

    de1_d    = VGA_DE_IN;
    hs1_d    = VGA_HSYNC_IN;
    vs1_d    = VGA_VSYNC_IN;
    black1_d = (mode_q == 2'd3);
    r1_d     = biased(VGA_RED_IN, bias);
    g1_d     = biased(VGA_GREEN_IN, bias);
    b1_d     = biased(VGA_BLUE_IN, bias);

    blank = !de1_q || black1_q;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    r2_d  = blank ? '0 : sat(r1_q);
    g2_d  = blank ? '0 : sat(g1_q);
    b2_d  = blank ? '0 : sat(b1_q);
  end

  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET_N) begin
      x_q      <= '0;
      y_q      <= '0;
      mode_q   <= '0;
      de1_q    <= 1'b0;
      hs1_q    <= !SYNC_POL;
      vs1_q    <= !SYNC_POL;
      black1_q <= 1'b0;
      r1_q     <= '0;
      g1_q     <= '0;
      b1_q     <= '0;
      hs2_q    <= !SYNC_POL;
      vs2_q    <= !SYNC_POL;
      r2_q     <= '0;
      g2_q     <= '0;
      b2_q     <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      mode_q   <= mode_d;
      de1_q    <= de1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      black1_q <= black1_d;
      r1_q     <= r1_d;
      g1_q     <= g1_d;
      b1_q     <= b1_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
      r2_q     <= r2_d;
      g2_q     <= g2_d;
      b2_q     <= b2_d;
    end
  end

  assign VGA_HSYNC   = hs2_q;
  assign VGA_VSYNC   = vs2_q;
  assign VGA_RED     = r2_q;
  assign VGA_GREEN   = g2_q;
  assign VGA_BLUE    = b2_q;
  assign MODE_ACTIVE = mode_q;

endmodule

// File: tb/tb_vga_dither_out.sv
// Scoreboard bench for vga_dither_out (IN_W=8, OUT_W=4, active-low syncs).
module tb_vga_dither_out;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       de_in = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
  logic [7:0] r_in = '0, g_in = '0, b_in = '0;
  logic       hs_out, vs_out;
  logic [3:0] r_out, g_out, b_out;
  logic [1:0] mode_act;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         due;
    logic [3:0] r, g, b;
    logic       hs, vs;
  } exp_t;
  exp_t sb[$];

  vga_dither_out #(.IN_W(8), .OUT_W(4), .SYNC_POL(1'b0)) dut (
    .CLK_25MHZ    (clk),
    .RESET_N      (rst_n),
    .MODE         (mode),
    .VGA_DE_IN    (de_in),
    .VGA_HSYNC_IN (hs_in),
    .VGA_VSYNC_IN (vs_in),
    .VGA_RED_IN   (r_in),
    .VGA_GREEN_IN (g_in),
    .VGA_BLUE_IN  (b_in),
    .VGA_HSYNC    (hs_out),
    .VGA_VSYNC    (vs_out),
    .VGA_RED      (r_out),
    .VGA_GREEN    (g_out),
    .VGA_BLUE     (b_out),
    .MODE_ACTIVE  (mode_act)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare each entry on the cycle it falls due.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("red", {28'd0, r_out}, {28'd0, e.r});
      chk("green", {28'd0, g_out}, {28'd0, e.g});
      chk("blue", {28'd0, b_out}, {28'd0, e.b});
      chk("hsync", {31'd0, hs_out}, {31'd0, e.hs});
      chk("vsync", {31'd0, vs_out}, {31'd0, e.vs});
    end
  end

  // Apply one pixel for one clock and queue its expected output two edges later.
  task automatic drive(input logic de, input logic hs, input logic vs,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb,
                       input logic ehs, input logic evs);
    exp_t e;
    de_in = de; hs_in = hs; vs_in = vs;
    r_in = r; g_in = g; b_in = b;
    e.due = cyc + 2;
    e.r = er; e.g = eg; e.b = eb; e.hs = ehs; e.vs = evs;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic blank_cycle(input logic vs);
    drive(1'b0, 1'b1, vs, 8'h00, 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 1'b1, vs);
  endtask

  logic [3:0] hi_row [4];

  initial begin
    // 1 where the dither threshold (B >= 8) lifts 0x78 to 0x8, indexed [y][x] by bit x.
    hi_row[0] = 4'b1010;
    hi_row[1] = 4'b0101;
    hi_row[2] = 4'b1010;
    hi_row[3] = 4'b0101;

    // Reset held 3 cycles with an active pixel and a non-zero MODE on the inputs.
    mode = 2'd2;
    repeat (3) drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    chk("reset_mode_active", {30'd0, mode_act}, 32'd0);
    chk("reset_red", {28'd0, r_out}, 32'd0);
    chk("reset_hsync", {31'd0, hs_out}, 32'd1);

    // Mode 0 truncation straight after release; first pixel lands exactly 2 edges later.
    rst_n = 1'b1;
    mode  = 2'd0;
    drive(1'b1, 1'b1, 1'b1, 8'h7F, 8'h80, 8'hFF, 4'h7, 4'h8, 4'hF, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 8'h7F, 8'h80, 8'hFF, 4'h7, 4'h8, 4'hF, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 8'h7F, 8'h80, 8'hFF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    chk("mode_still_0", {30'd0, mode_act}, 32'd0);

    // Vsync edge latches round mode.
    mode = 2'd1;
    blank_cycle(1'b0);
    blank_cycle(1'b1);
    chk("mode_latch_1", {30'd0, mode_act}, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 8'h78, 8'h77, 8'hFF, 4'h8, 4'h7, 4'hF, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 8'h78, 8'h77, 8'hFF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);

    // Vsync already active above with MODE=1; return inactive, then edge into dither mode.
    mode = 2'd2;
    blank_cycle(1'b1);
    blank_cycle(1'b0);
    blank_cycle(1'b1);
    chk("mode_latch_2", {30'd0, mode_act}, 32'd2);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        logic [3:0] ev;
        ev = hi_row[y][x] ? 4'h8 : 4'h7;
        drive(1'b1, 1'b1, 1'b1, 8'h78, 8'h78, 8'h70, ev, ev, 4'h7, 1'b1, 1'b1);
      end
      blank_cycle(1'b1);
    end

    // MODE changed mid-frame: dithering continues (x1,y0 still 0x8) until the vsync edge.
    mode = 2'd0;
    drive(1'b1, 1'b1, 1'b1, 8'h78, 8'h78, 8'h78, 4'h7, 4'h7, 4'h7, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 8'h78, 8'h78, 8'h78, 4'h8, 4'h8, 4'h8, 1'b1, 1'b1);
    chk("mode_held_2", {30'd0, mode_act}, 32'd2);
    blank_cycle(1'b1);
    blank_cycle(1'b0);
    blank_cycle(1'b1);
    chk("mode_latch_0", {30'd0, mode_act}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 8'h78, 8'h78, 8'h78, 4'h7, 4'h7, 4'h7, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 8'h78, 8'h78, 8'h78, 4'h7, 4'h7, 4'h7, 1'b1, 1'b1);
    blank_cycle(1'b1);

    // Force black: colours 0, syncs still follow with the same delay.
    mode = 2'd3;
    blank_cycle(1'b0);
    blank_cycle(1'b1);
    chk("mode_latch_3", {30'd0, mode_act}, 32'd3);
    drive(1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);

    de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_dither_out.md
Name: vga_dither_out

Overview:
- Parametrised VGA colour output stage between the video generator (full-depth RGB, syncs, data-enable) and the board DAC pins.
- Replaces plain MSB truncation with selectable truncate, round or ordered 4x4 Bayer dither, reducing IN_W-bit channels to OUT_W bits.
- Delays syncs to stay aligned with colour, blanks colour outside active video, and changes mode only at frame boundaries.

Parameters:
IN_W, 8, input colour width per channel
OUT_W, 4, output colour width per channel; legal range 1 <= OUT_W < IN_W, otherwise elaboration error
SYNC_POL, 0, active level of HSYNC/VSYNC (0 = active-low)

Ports:
CLK_25MHZ  in  1  pixel clock
RESET_N  in  1  synchronous reset, active-low
MODE  in  2  0 truncate, 1 round, 2 Bayer dither, 3 force black
VGA_DE_IN  in  1  active-video enable
VGA_HSYNC_IN  in  1  horizontal sync
VGA_VSYNC_IN  in  1  vertical sync
VGA_RED_IN  in  IN_W  red
VGA_GREEN_IN  in  IN_W  green
VGA_BLUE_IN  in  IN_W  blue
VGA_HSYNC  out  1  hsync, delayed 2 cycles
VGA_VSYNC  out  1  vsync, delayed 2 cycles
VGA_RED  out  OUT_W  reduced red
VGA_GREEN  out  OUT_W  reduced green
VGA_BLUE  out  OUT_W  reduced blue
MODE_ACTIVE  out  2  mode currently applied

Behaviour:
- Reset and clocking: single clock. All registers reset synchronously while RESET_N=0.
- Reset values:
  - colour outputs 0.
  - VGA_HSYNC/VGA_VSYNC = !SYNC_POL (inactive level).
  - MODE_ACTIVE 0; x/y counters 0; pipeline DE 0.
- Latency: fixed 2 cycles from every input to every output. Syncs pass through the same 2 pipeline stages as colour.
  - Stage 1 registers inputs and computes the biased sums.
  - Stage 2 applies saturation/truncation/blanking and registers the outputs.
- Pixel counters (2-bit x, 2-bit y, both wrap mod 4):
  - x increments on each cycle with DE_IN=1.
  - x clears on the first cycle with DE_IN=0 after DE_IN=1 (end of line); y increments on that same cycle.
  - y clears every cycle VSYNC_IN is at its active level.
  - Both clear on reset.
- Mode latch:
  - MODE is sampled into MODE_ACTIVE only on the inactive-to-active edge of VGA_VSYNC_IN.
  - Changes mid-frame are ignored until the next such edge.
- Shift S = IN_W-OUT_W. Sums are computed in IN_W+1 bits, saturate to 2^IN_W-1, then the top OUT_W bits are taken:
  - Mode 0: out = in[IN_W-1:S].
  - Mode 1: sum = in + 2^(S-1).
  - Mode 2: sum = in + bias.
    - Matrix rows by y: 0 8 2 10 / 12 4 14 6 / 3 11 1 9 / 15 7 13 5, indexed [y][x] with x, y from the pixel counters.
    - bias = B[y][x] << (S-4) when S >= 4, else B[y][x] >> (4-S).
    - The same bias applies to all three channels.
  - Mode 3: all channels 0; syncs unaffected.
- Blanking: any pixel whose DE_IN was 0 outputs colour 0 in every mode.
- Reset mid-line: outputs go to reset values on the next edge. The first post-reset pixel uses x=y=0 and mode 0 until the next vsync edge.
- No backpressure; one pixel is accepted per clock unconditionally.

Test Plan:
- IN_W=8, OUT_W=4, reset held 3 cycles -> colours 0, syncs 1, MODE_ACTIVE=0. After release, the input pattern appears exactly 2 cycles later.
- Mode 0, RGB=0x7F/0x80/0xFF with DE=1 -> 0x7/0x8/0xF. With DE=0 the same input -> 0/0/0.
- Mode 1, RGB=0x78/0x77/0xFF -> 0x8/0x7/0xF (saturation checked on 0xFF).
- Mode 2, constant 0x78 over a 4x4 pixel block -> (x0,y0)=0x7, (x1,y0)=0x8. Exactly 8 of 16 pixels are 0x8; pattern matches the matrix at threshold >=8.
- MODE written 2->0 mid-frame -> MODE_ACTIVE stays 2 and dithering continues until the vsync active edge. The first pixel after that edge is truncated.
- Mode 3 with RGB=0xFF and sync toggling -> colours 0 while HSYNC/VSYNC still follow the inputs with 2-cycle delay.
